alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/alu_issue_imm_gen.sv | 19 +
 rtl/alu_issue.sv | 138 +++++++++++++
 tb/tb_alu_issue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants and 4-bit ALU operation encodings,
// used by the issue stage and the ALU itself.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // Encoding is {funct7[5], funct3} so OP instructions map straight through.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/alu_issue_imm_gen.sv
// Immediate generator: I-type and U-type immediates, sign-extended from instr[31].
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:12]     instr_i,
    output logic [XLEN-1:0]  imm_i_o,
    output logic [XLEN-1:0]  imm_u_o
);

    logic signed [11:0] imm_i12;
    logic signed [31:0] imm_u32;

    assign imm_i12 = instr_i[31:20];
    assign imm_u32 = {instr_i[31:12], 12'b0};

    assign imm_i_o = XLEN'(imm_i12);
    assign imm_u_o = XLEN'(imm_u32);

endmodule

// File: rtl/alu_issue.sv
// Single-entry issue register between decode and EX: decodes ALU-class RV32I
// instructions, applies writeback bypass at accept and holds results under backpressure.
module alu_issue
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_operand1,
    output logic [XLEN-1:0]  out_operand2,
    output logic [3:0]       out_alu_op,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, pc_q;
    logic [3:0]      alu_q, alu_d;
    logic [4:0]      rd_q;
    logic            we_q, we_d, ill_q, ill_d;

    logic [XLEN-1:0] imm_i, imm_u, rs1_val, rs2_val;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic            accept, supported;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr[31:12]),
        .imm_i_o (imm_i),
        .imm_u_o (imm_u)
    );

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Bypass only ever looks at the instruction being accepted; held contents stay as captured.
    assign rs1_val = (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : in_rs1_data;
    assign rs2_val = (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : in_rs2_data;

    always_comb begin
        op1_d     = '0;
        op2_d     = '0;
        alu_d     = ALU_ADD;
        supported = 1'b1;
        unique case (opcode)
            OP: begin
                op1_d = rs1_val;
                op2_d = rs2_val;
                alu_d = {in_instr[30], funct3};
            end
            OP_IMM: begin
                op1_d = rs1_val;
                alu_d = (funct3 == F3_SRX) ? {in_instr[30], funct3} : {1'b0, funct3};
                // Shift-immediates carry funct7 in imm[11:5]; only the shamt is an operand.
                op2_d = (funct3 == F3_SLL || funct3 == F3_SRX) ? XLEN'(rs2) : imm_i;
            end
            LUI: begin
                op2_d = imm_u;
            end
            AUIPC: begin
                op1_d = in_pc;
                op2_d = imm_u;
            end
            default: supported = 1'b0;
        endcase
        we_d  = supported && (rd != 5'd0);
        ill_d = !supported;
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (accept)
            state_d = FULL;
        else if (out_ready)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            op1_q   <= '0;
            op2_q   <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op1_q <= op1_d;
                op2_q <= op2_d;
                alu_q <= alu_d;
                rd_q  <= rd;
                we_q  <= we_d;
                ill_q <= ill_d;
                pc_q  <= in_pc;
            end
        end
    end

    assign out_valid    = (state_q == FULL);
    assign out_operand1 = op1_q;
    assign out_operand2 = op2_q;
    assign out_alu_op   = alu_q;
    assign out_rd       = rd_q;
    assign out_we       = we_q;
    assign out_illegal  = ill_q;
    assign out_pc       = pc_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed RV32I vectors with hand-computed
// operands, plus backpressure, flush and asynchronous reset scenarios.
module tb_alu_issue;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_rs1_data = '0;
    logic [XLEN-1:0] in_rs2_data = '0;
    logic            wb_valid = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_operand1, out_operand2, out_pc;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rd;
    logic            out_we, out_illegal;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t held;
    int   n_vec = 0;
    int   n_err = 0;

    alu_issue #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_operand1 (out_operand1),
        .out_operand2 (out_operand2),
        .out_alu_op   (out_alu_op),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .out_illegal  (out_illegal),
        .out_pc       (out_pc)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                                input logic [3:0] alu, input logic [4:0] rd,
                                input logic we, input logic ill, input logic [31:0] pc);
        mk = {op1, op2, alu, rd, we, ill, pc};
    endfunction

    function automatic exp_t cur();
        cur = {out_operand1, out_operand2, out_alu_op, out_rd, out_we, out_illegal, out_pc};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                        input exp_t e);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        wb_valid    = wbv;
        wb_rd       = wbrd;
        wb_data     = wbd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    // Monitor: a consumed output is compared; a held output killed by flush is dropped.
    always @(negedge clk) begin
        if (!rst && out_valid && (out_ready || flush)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %h required none", cur());
            end else begin
                mon_e = sb.pop_front();
                if (out_ready) chk("scoreboard", cur(), mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_outputs", cur(), '0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // Back-to-back stream with the consumer always ready.
        send(32'h402081B3, 32'h40,  32'd5,        32'd7, 0, 5'd0, 0, mk(32'd5, 32'd7, 4'b1000, 5'd3, 1, 0, 32'h40));
        send(32'h4030D213, 32'h44,  32'h80000000, 32'd0, 0, 5'd0, 0, mk(32'h80000000, 32'd3, 4'b1101, 5'd4, 1, 0, 32'h44));
        send(32'hFFF00293, 32'h48,  32'd0,        32'd0, 0, 5'd0, 0, mk(32'd0, 32'hFFFFFFFF, 4'b0000, 5'd5, 1, 0, 32'h48));
        send(32'h12345317, 32'h100, 32'h111,      32'h222, 0, 5'd0, 0, mk(32'h100, 32'h12345000, 4'b0000, 5'd6, 1, 0, 32'h100));
        send(32'hABCDE3B7, 32'h104, 32'h111,      32'h222, 0, 5'd0, 0, mk(32'd0, 32'hABCDE000, 4'b0000, 5'd7, 1, 0, 32'h104));
        send(32'h00208433, 32'h108, 32'd0,        32'd4, 1, 5'd1, 32'hDEADBEEF, mk(32'hDEADBEEF, 32'd4, 4'b0000, 5'd8, 1, 0, 32'h108));
        send(32'h00208433, 32'h10C, 32'd0,        32'd4, 1, 5'd0, 32'hDEADBEEF, mk(32'd0, 32'd4, 4'b0000, 5'd8, 1, 0, 32'h10C));
        send(32'h00208433, 32'h110, 32'd9,        32'd4, 1, 5'd2, 32'h55, mk(32'd9, 32'h55, 4'b0000, 5'd8, 1, 0, 32'h110));
        send(32'h00208033, 32'h114, 32'd1,        32'd2, 0, 5'd0, 0, mk(32'd1, 32'd2, 4'b0000, 5'd0, 0, 0, 32'h114));
        send(32'h0000A483, 32'h118, 32'h77,       32'h88, 0, 5'd0, 0, mk(32'd0, 32'd0, 4'b0000, 5'd9, 0, 1, 32'h118));
        send(32'h0F00E513, 32'h11C, 32'h0F,       32'd0, 0, 5'd0, 0, mk(32'h0F, 32'hF0, 4'b0110, 5'd10, 1, 0, 32'h11C));
        send(32'h4020D5B3, 32'h120, 32'hF0000000, 32'd4, 0, 5'd0, 0, mk(32'hF0000000, 32'd4, 4'b1101, 5'd11, 1, 0, 32'h120));
        send(32'h0020B633, 32'h124, 32'd3,        32'd8, 0, 5'd0, 0, mk(32'd3, 32'd8, 4'b0011, 5'd12, 1, 0, 32'h124));
        drain("stream_drain");

        // Backpressure: hold an entry for three cycles while another instruction waits.
        out_ready = 1'b0;
        held = mk(32'd5, 32'd7, 4'b1000, 5'd3, 1, 0, 32'h200);
        send(32'h402081B3, 32'h200, 32'd5, 32'd7, 0, 5'd0, 0, held);
        in_valid    = 1'b1;
        in_instr    = 32'hABCDE3B7;
        in_pc       = 32'h204;
        wb_valid    = 1'b1;
        wb_rd       = 5'd1;
        wb_data     = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_hold", cur(), held);
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        flush    = 1'b1;
        in_instr = 32'hFFF00293;
        in_pc    = 32'h208;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_clears_valid", out_valid, 1'b0);
        chk("flush_held_dropped", sb.size(), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_new_dropped", out_valid, 1'b0);

        // Asynchronous reset while an entry is held.
        out_ready = 1'b0;
        send(32'h12345317, 32'h300, 32'd0, 32'd0, 0, 5'd0, 0, mk(32'h300, 32'h12345000, 4'b0000, 5'd6, 1, 0, 32'h300));
        chk("full_before_rst", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_in_ready", in_ready, 1'b1);
        chk("rst_async_outputs", cur(), '0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(32'hFFF00293, 32'h400, 32'd0, 32'd0, 0, 5'd0, 0, mk(32'd0, 32'hFFFFFFFF, 4'b0000, 5'd5, 1, 0, 32'h400));
        drain("post_reset_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
